// File: rtl/master_cmd_queue_if.sv
// Command/response and bus-master handshake bundle for master_cmd_queue.
// slave = queue view, master = host/bus-side view.
interface master_cmd_queue_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_mode;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_mode;
  logic              rsp_err;
  logic              m_U_start;
  logic [ADDR_W-1:0] m_U_addr;
  logic [DATA_W-1:0] m_U_wdata;
  logic              m_U_mode;
  logic [DATA_W-1:0] m_U_rdata;
  logic              m_done;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_mode,
    input  m_U_rdata, m_done,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_mode, rsp_err,
    output m_U_start, m_U_addr, m_U_wdata, m_U_mode
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_mode,
    output m_U_rdata, m_done,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_mode, rsp_err,
    input  m_U_start, m_U_addr, m_U_wdata, m_U_mode
  );
endinterface

// File: rtl/master_cmd_queue.sv
// FIFO-fed command sequencer in front of one bus master user port.
// Optional WAIT timeout abort enabled by defining MCQ_TIMEOUT_EN.
module master_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  master_cmd_queue_if.slave      bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              mode_mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop, fin, abort, tmo_hit;

  logic              start_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mode_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_mode_q;

  // cmd_ready comes straight from the registered count, so a pop in
  // the same cycle never opens a slot for a push into a full FIFO.
  assign bus.cmd_ready = (count != CW'(DEPTH));
  assign push = bus.cmd_valid && bus.cmd_ready;

  assign bus.m_U_start = start_q;
  assign bus.m_U_addr  = addr_q;
  assign bus.m_U_wdata = wdata_q;
  assign bus.m_U_mode  = mode_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_mode  = rsp_mode_q;

  assign busy = (state_q != IDLE) || (count != '0);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.m_done) begin
          fin     = 1'b1;
          state_d = RESP;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= bus.cmd_addr;
      data_mem[wr_ptr] <= bus.cmd_wdata;
      mode_mem[wr_ptr] <= bus.cmd_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mode_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_mode_q  <= 1'b0;
    end else begin
      rsp_valid_q <= (state_q == RESP);
      if (pop) begin
        start_q <= 1'b1;
        addr_q  <= addr_mem[rd_ptr];
        wdata_q <= data_mem[rd_ptr];
        mode_q  <= mode_mem[rd_ptr];
      end
      if (fin || abort) begin
        start_q     <= 1'b0;
        rsp_mode_q  <= mode_q;
        rsp_rdata_q <= (fin && !mode_q) ? bus.m_U_rdata : '0;
      end
    end
  end

`ifdef MCQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // pre-edge count of TIMEOUT-1 means this edge ends the TIMEOUT-th WAIT cycle
  assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT - 1));
  assign bus.rsp_err = err_q;

  always_ff @(posedge clk) begin
    if (rst || pop)           tmo_cnt <= '0;
    else if (state_q == WAIT) tmo_cnt <= tmo_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)        err_q <= 1'b0;
    else if (fin)   err_q <= 1'b0;
    else if (abort) err_q <= 1'b1;
  end
`else
  assign tmo_hit     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

endmodule
